// File: rtl/forward_select_unit.sv
// EX-operand forwarding selects and load-use stall for the 5-stage core.
// FORWARD_SEL_FWD_EN enables bypass selects; undefined, dependents stall instead.
module forward_select_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  idUsesRs,
    input  logic                  idUsesRt,
    input  logic [REG_ADDR_W-1:0] idDst,
    input  logic                  idRegWrite,
    input  logic                  idMemRead,
    input  logic                  flush,
    input  logic                  freeze,
    output logic [1:0]            fwdA,
    output logic [1:0]            fwdB,
    output logic                  stall
);

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic                  memRead;
        logic [REG_ADDR_W-1:0] dst;
    } slot_t;

    slot_t exSlot, memSlot, wbSlot;

    logic useA, useB;
    logic exA, exB, memA, memB;
    logic bubble;

    function automatic logic hit(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.regWrite && (s.dst != '0) && (s.dst == r);
    endfunction

    assign useA = idValid & idUsesRs;
    assign useB = idValid & idUsesRt;
    assign exA  = useA & hit(exSlot, idRs);
    assign exB  = useB & hit(exSlot, idRt);
    assign memA = useA & hit(memSlot, idRs);
    assign memB = useB & hit(memSlot, idRt);

`ifdef FORWARD_SEL_FWD_EN
    assign stall = exSlot.memRead & (exA | exB);
`else
    assign stall = exA | exB | memA | memB;
`endif

    assign bubble = stall | flush | ~idValid;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            exSlot  <= '0;
            memSlot <= '0;
            wbSlot  <= '0;
        end else if (!freeze) begin
            wbSlot  <= memSlot;
            memSlot <= exSlot;
            exSlot  <= bubble ? '0 : {1'b1, idRegWrite, idMemRead, idDst};
        end
    end

    // WB producers are covered by regfile write-through; kept for shape only
    logic unusedWb;
    assign unusedWb = ^wbSlot;

`ifdef FORWARD_SEL_FWD_EN
    logic [1:0] fwdANext, fwdBNext;

    always_comb begin
        fwdANext = 2'b00;
        fwdBNext = 2'b00;
        priority case (1'b1)
            bubble:  fwdANext = 2'b00;
            exA:     fwdANext = 2'b01;
            memA:    fwdANext = 2'b10;
            default: fwdANext = 2'b00;
        endcase
        priority case (1'b1)
            bubble:  fwdBNext = 2'b00;
            exB:     fwdBNext = 2'b01;
            memB:    fwdBNext = 2'b10;
            default: fwdBNext = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fwdA <= 2'b00;
            fwdB <= 2'b00;
        end else if (!freeze) begin
            fwdA <= fwdANext;
            fwdB <= fwdBNext;
        end
    end
`else
    assign fwdA = 2'b00;
    assign fwdB = 2'b00;
`endif

endmodule

// File: tb/tb_forward_select_unit.sv
// Directed vector bench for forward_select_unit.
// Expectations follow whichever FORWARD_SEL_FWD_EN build is compiled.
module tb_forward_select_unit;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       idValid = 1'b0;
    logic [4:0] idRs = '0;
    logic [4:0] idRt = '0;
    logic       idUsesRs = 1'b0;
    logic       idUsesRt = 1'b0;
    logic [4:0] idDst = '0;
    logic       idRegWrite = 1'b0;
    logic       idMemRead = 1'b0;
    logic       flush = 1'b0;
    logic       freeze = 1'b0;
    logic [1:0] fwdA, fwdB;
    logic       stall;

    int compared = 0;
    int failed = 0;

    forward_select_unit dut (
        .clk(clk), .rstN(rstN), .idValid(idValid),
        .idRs(idRs), .idRt(idRt),
        .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
        .idDst(idDst), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
        .flush(flush), .freeze(freeze),
        .fwdA(fwdA), .fwdB(fwdB), .stall(stall)
    );

    always #5 clk = ~clk;

    // One row per cycle: ID inputs, expected stall for that ID instruction,
    // expected selects of the instruction currently in EX.
    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       ur, ut;
        logic [4:0] dst;
        logic       rw, mr, fl, fz;
        logic       st;
        logic [1:0] a, b;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input int v, input int rs, input int rt,
                                input int ur, input int ut, input int dst,
                                input int rw, input int mr, input int fl,
                                input int fz, input int st, input int a,
                                input int b);
        row_t r;
        r.v = 1'(v); r.rs = 5'(rs); r.rt = 5'(rt);
        r.ur = 1'(ur); r.ut = 1'(ut); r.dst = 5'(dst);
        r.rw = 1'(rw); r.mr = 1'(mr); r.fl = 1'(fl); r.fz = 1'(fz);
        r.st = 1'(st); r.a = 2'(a); r.b = 2'(b);
        return r;
    endfunction

    function automatic row_t nop(input int st, input int a, input int b);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, a, b);
    endfunction

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic idle();
        idValid = 0; idRs = 0; idRt = 0; idUsesRs = 0; idUsesRt = 0;
        idDst = 0; idRegWrite = 0; idMemRead = 0; flush = 0; freeze = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic runRows(input string tag);
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            idValid = rows[i].v; idRs = rows[i].rs; idRt = rows[i].rt;
            idUsesRs = rows[i].ur; idUsesRt = rows[i].ut;
            idDst = rows[i].dst; idRegWrite = rows[i].rw;
            idMemRead = rows[i].mr; flush = rows[i].fl; freeze = rows[i].fz;
            #1;
            chk($sformatf("%s[%0d].stall", tag, i), {1'b0, stall}, {1'b0, rows[i].st});
            chk($sformatf("%s[%0d].fwdA", tag, i), fwdA, rows[i].a);
            chk($sformatf("%s[%0d].fwdB", tag, i), fwdB, rows[i].b);
        end
        rows.delete();
    endtask

    task automatic randInputs();
        idValid = 1'($urandom); idRs = 5'($urandom); idRt = 5'($urandom);
        idUsesRs = 1'($urandom); idUsesRt = 1'($urandom);
        idDst = 5'($urandom); idRegWrite = 1'($urandom);
        idMemRead = 1'($urandom); flush = 1'($urandom); freeze = 1'($urandom);
    endtask

    initial begin
        // reset with toggling inputs
        rstN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            randInputs();
            #1;
            chk($sformatf("rst[%0d].stall", i), {1'b0, stall}, 2'b00);
            chk($sformatf("rst[%0d].fwdA", i), fwdA, 2'b00);
            chk($sformatf("rst[%0d].fwdB", i), fwdB, 2'b00);
        end
        @(negedge clk);
        randInputs();
        idValid = 1; idUsesRs = 1; idUsesRt = 1; flush = 0; freeze = 0;
        rstN = 1'b1;
        #1;
        chk("rstRel.stall", {1'b0, stall}, 2'b00);
        @(posedge clk);
        #1;
        chk("rstEdge1.fwdA", fwdA, 2'b00);
        chk("rstEdge1.fwdB", fwdB, 2'b00);

`ifdef FORWARD_SEL_FWD_EN
        // add $3 ; sub $5,$3,$4
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 1, 0));
        rows.push_back(nop(0, 0, 0));
        runRows("exFwd");

        // add $3 ; nop ; sub $5,$3,$4
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 2, 0));
        runRows("memFwd");

        // lw $2 ; and $6,$2,$2
        doReset();
        rows.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 2, 2));
        rows.push_back(nop(0, 0, 0));
        runRows("loadUse");

        // $0 producer (a load) and a non-writing load
        doReset();
        rows.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 1, 0, 6, 0, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 6, 6, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 0, 0));
        runRows("zeroReg");

        // two producers of $7, newest wins; freeze holds selects
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 4, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        rows.push_back(nop(0, 1, 1));
        rows.push_back(nop(0, 0, 0));
        runRows("newest");

        // load-use with freeze held 3 cycles
        doReset();
        rows.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 2, 2));
        rows.push_back(nop(0, 0, 0));
        runRows("frzLoad");

        // flush with and without stall; per-operand uses bits
        doReset();
        rows.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 1, 0, 1, 0, 0));
        rows.push_back(nop(0, 0, 0));
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 1, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 3, 3, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 0, 1));
        runRows("flushUse");
`else
        // add $3 ; sub $5,$3,$4 stalls two cycles
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 0, 0));
        runRows("stall2");

        // add ; nop ; sub stalls one cycle
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(nop(0, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        runRows("stall1");

        // flush during stall: sub never enters EX
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 1, 0, 1, 0, 0));
        rows.push_back(mk(1, 8, 9, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 5, 0, 1, 0, 11, 1, 0, 0, 0, 0, 0, 0));
        runRows("flush");

        // $0 producer and non-writing producer never stall
        doReset();
        rows.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 6, 6, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 6, 6, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0));
        runRows("zeroReg");

        // freeze held 3 cycles mid-stall
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        runRows("freeze");

        // uses bits and idValid gate participation
        doReset();
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 3, 4, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 3, 3, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 4, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0));
        runRows("uses");
`endif

        // reset mid-stall drops stall at once
        doReset();
        rows.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 2, 2, 1, 1, 6, 1, 0, 0, 0, 1, 0, 0));
        runRows("preRst");
        rstN = 1'b0;
        #1;
        chk("midRst.stall", {1'b0, stall}, 2'b00);
        chk("midRst.fwdA", fwdA, 2'b00);
        chk("midRst.fwdB", fwdB, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
